sar_logic: RTL
==============

Name: sar_logic

Overview:
- Successive-approximation controller directly downstream of the SAR ADC comparator (preamp + senseamp chain).
- Sequences one conversion: track phase, then one comparator strobe per bit, MSB first.
- Consumes the comparator's resolved out/outb pair and drives the capacitive-DAC trial code back to the analog front end.
- Presents the final N-bit word with a one-cycle valid pulse. Pure digital logic; comparator timing is abstracted as a programmable wait.

Parameters:
N, 8, conversion resolution in bits (N >= 2)
T_SAMPLE, 2, cycles the sample (track) output is held high per conversion (>= 1)
CMP_WAIT, 1, cycles between comparator strobe and decision (>= 0), covers preamp + latch resolution
CONT, 0, 1 = restart a new conversion automatically after DONE; 0 = wait for start

Ports:
clk  input  1  controller clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
pdn  input  1  1 = normal operation, 0 = powered down (aborts conversion, forces IDLE)
start  input  1  conversion request, sampled in IDLE only
cmp_out  input  1  comparator positive output (1 = vin > vdac)
cmp_outb  input  1  comparator complementary output
sample  output  1  track-phase control to sampling switches
cmp_en  output  1  comparator strobe, one cycle per bit
dac_code  output  N  trial code to DAC
data_out  output  N  last completed conversion result, held
valid  output  1  one-cycle pulse when data_out updates
busy  output  1  high from leaving IDLE until DONE inclusive
meta_err  output  1  at least one bit in the last conversion had cmp_out == cmp_outb; updates with valid

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; sample=0, cmp_en=0, dac_code=0, data_out=0, valid=0, busy=0, meta_err=0; counters cleared. rst has priority over pdn and start.
- pdn=0 at an edge:
  - state=IDLE; sample=0, cmp_en=0, dac_code=0, busy=0, valid=0.
  - data_out and meta_err hold.
  - Partial conversion discarded; no valid.
- States: IDLE, SAMPLE, STROBE, WAIT, DECIDE, DONE.
- IDLE: start=1 and pdn=1 at an edge -> SAMPLE; busy=1 from that edge.
- SAMPLE: sample=1 for exactly T_SAMPLE cycles, dac_code=0. On exit:
  - dac_code = 1<<(N-1); bit index i = N-1; internal meta flag cleared.
  - -> STROBE.
- STROBE: cmp_en=1 for one cycle; dac_code stable. -> WAIT if CMP_WAIT>0, else -> DECIDE.
- WAIT: CMP_WAIT cycles, cmp_en=0. -> DECIDE.
- DECIDE: evaluate comparator at this edge.
  - cmp_out=1, cmp_outb=0: keep bit i.
  - cmp_out=0, cmp_outb=1: clear bit i.
  - cmp_out == cmp_outb (unresolved): clear bit i and set internal meta flag.
  - If i>0: set bit i-1, i=i-1, -> STROBE.
  - If i=0: -> DONE.
- DONE, one cycle:
  - data_out = final code; meta_err = internal meta flag; valid=1; busy=1.
  - Next state: CONT=1 and pdn=1 -> SAMPLE (busy stays 1); otherwise -> IDLE (busy=0, dac_code=0).
- Bit period = CMP_WAIT+2 cycles.
- Latency: start sampled at edge k -> valid high in cycle k+1+T_SAMPLE+N*(CMP_WAIT+2) (one cycle beyond the last DECIDE).
- start outside IDLE is ignored, not queued.
- start held high in IDLE with CONT=0 starts back-to-back conversions, each separated by one IDLE cycle.
- dac_code changes only on SAMPLE exit and DECIDE edges. Each trial bit is set before its strobe.
- cmp_en never asserts in IDLE, SAMPLE, or DONE.
- Comparator inputs are sampled only in DECIDE; values in other states are ignored.

Test Plan:
- Reset then idle: rst=1 for 3 cycles, drop -> all outputs 0; with start=0 for 20 cycles, busy=0, cmp_en never 1.
- Nominal conversion, N=4, T_SAMPLE=2, CMP_WAIT=1: bench comparator returns (10 >= dac_code) at each DECIDE; pulse start -> dac_code sequence 8,12,10,11; data_out=10; valid 15 cycles after start edge; meta_err=0; exactly 4 cmp_en pulses.
- Extremes, N=8: model input 255 -> data_out=255; input 0 -> data_out=0; model input 128 -> data_out=128; each with 8 strobes.
- Unresolved comparator: N=4, force cmp_out=cmp_outb=1 at the 2nd DECIDE only, otherwise model 15 -> bit2 cleared, data_out=11, meta_err=1. Next clean conversion -> meta_err=0.
- Abort: drop pdn to 0 during the 3rd WAIT -> next cycle IDLE, busy=0, dac_code=0, no valid; data_out retains the previous value. Start after pdn=1 converts normally.
- CONT=1: single start pulse -> valid pulses every 1+T_SAMPLE+N*(CMP_WAIT+2) cycles (15 for the N=4 config) with busy continuously 1. A start pulse mid-conversion changes nothing. rst mid-conversion -> all outputs 0 next cycle.

Source files
------------

// File: rtl/sar_logic.sv
// sar_logic: successive-approximation controller for a SAR ADC
//   clk, rst       : controller clock, synchronous active-high reset
//   pdn            : 1 = normal operation, 0 = power down (aborts, forces IDLE)
//   start          : conversion request, honoured only in IDLE
//   cmp_out/outb   : comparator decision pair, sampled only in DECIDE
//   sample         : track-phase control for the sampling switches
//   cmp_en         : comparator strobe, one cycle per bit
//   dac_code       : trial code to the capacitive DAC
//   data_out       : last completed conversion result, held
//   valid          : one-cycle pulse when data_out updates
//   busy           : high from leaving IDLE until DONE inclusive
//   meta_err       : last result had at least one unresolved decision
module sar_logic #(
    parameter int N        = 8,
    parameter int T_SAMPLE = 2,
    parameter int CMP_WAIT = 1,
    parameter bit CONT     = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         pdn,
    input  logic         start,
    input  logic         cmp_out,
    input  logic         cmp_outb,
    output logic         sample,
    output logic         cmp_en,
    output logic [N-1:0] dac_code,
    output logic [N-1:0] data_out,
    output logic         valid,
    output logic         busy,
    output logic         meta_err
);
    localparam int CMAX = (T_SAMPLE > CMP_WAIT) ? T_SAMPLE : CMP_WAIT;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int IW   = $clog2(N);

    typedef enum logic [2:0] {IDLE, SAMPLE, STROBE, WAIT, DECIDE, DONE} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [IW-1:0] idx_q;
    logic [N-1:0]  dac_q, data_q, bit_sel, code_d;
    logic          sample_q, cmp_en_q, valid_q, busy_q, meta_err_q, meta_q;
    logic          keep, meta_d;

    assign bit_sel = {{(N-1){1'b0}}, 1'b1} << idx_q;
    // Only a clean 1/0 pair keeps the trial bit; an unresolved pair clears it and is flagged.
    assign keep    = cmp_out & ~cmp_outb;
    assign code_d  = keep ? dac_q : (dac_q & ~bit_sel);
    assign meta_d  = meta_q | (cmp_out == cmp_outb);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            dac_q      <= '0;
            data_q     <= '0;
            sample_q   <= 1'b0;
            cmp_en_q   <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            meta_err_q <= 1'b0;
            meta_q     <= 1'b0;
        end else if (!pdn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            dac_q    <= '0;
            sample_q <= 1'b0;
            cmp_en_q <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            meta_q   <= 1'b0;
        end else begin
            valid_q  <= 1'b0;
            cmp_en_q <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    state_q  <= SAMPLE;
                    sample_q <= 1'b1;
                    busy_q   <= 1'b1;
                    cnt_q    <= CW'(T_SAMPLE - 1);
                end
                SAMPLE: if (cnt_q == '0) begin
                    state_q  <= STROBE;
                    sample_q <= 1'b0;
                    cmp_en_q <= 1'b1;
                    dac_q    <= {1'b1, {(N-1){1'b0}}};
                    idx_q    <= IW'(N - 1);
                    meta_q   <= 1'b0;
                end else begin
                    cnt_q <= cnt_q - 1'b1;
                end
                STROBE: if (CMP_WAIT > 0) begin
                    state_q <= WAIT;
                    cnt_q   <= CW'(CMP_WAIT - 1);
                end else begin
                    state_q <= DECIDE;
                end
                WAIT: if (cnt_q == '0) begin
                    state_q <= DECIDE;
                end else begin
                    cnt_q <= cnt_q - 1'b1;
                end
                DECIDE: begin
                    meta_q <= meta_d;
                    if (idx_q == '0) begin
                        state_q    <= DONE;
                        dac_q      <= code_d;
                        data_q     <= code_d;
                        meta_err_q <= meta_d;
                        valid_q    <= 1'b1;
                    end else begin
                        // Next trial bit sits directly below the one just resolved.
                        state_q  <= STROBE;
                        cmp_en_q <= 1'b1;
                        dac_q    <= code_d | (bit_sel >> 1);
                        idx_q    <= idx_q - 1'b1;
                    end
                end
                DONE: begin
                    dac_q <= '0;
                    if (CONT) begin
                        state_q  <= SAMPLE;
                        sample_q <= 1'b1;
                        cnt_q    <= CW'(T_SAMPLE - 1);
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sample   = sample_q;
    assign cmp_en   = cmp_en_q;
    assign dac_code = dac_q;
    assign data_out = data_q;
    assign valid    = valid_q;
    assign busy     = busy_q;
    assign meta_err = meta_err_q;
endmodule
